// File: rtl/bin_to_bcd4_if.sv
// Handshake/data bundle between a requester and the bin_to_bcd4 converter.
// Directions are named from the converter's side: i_ into it, o_ out of it.
interface bin_to_bcd4_if #(
  parameter int BIN_W = 14
);
  logic             i_start;
  logic [BIN_W-1:0] i_bin;
  logic [15:0]      o_d;
  logic             o_busy;
  logic             o_done;
  logic             o_ovf;

  modport master (
    output i_start,
    output i_bin,
    input  o_d,
    input  o_busy,
    input  o_done,
    input  o_ovf
  );

  modport slave (
    input  i_start,
    input  i_bin,
    output o_d,
    output o_busy,
    output o_done,
    output o_ovf
  );
endinterface

// File: rtl/bin_to_bcd4.sv
// Sequential double-dabble binary -> 4-digit packed BCD converter (one bit per clock).
// Optional macro BCD_OVF_BLANK_EN: overflow result is 16'hFFFF (blank) instead of 16'h9999.
module bin_to_bcd4 #(
  parameter int BIN_W = 14
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  bin_to_bcd4_if.slave  bif
);

  localparam int CNT_W = 5;

`ifdef BCD_OVF_BLANK_EN
  localparam logic [15:0] OVF_D = 16'hFFFF;
`else
  localparam logic [15:0] OVF_D = 16'h9999;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [BIN_W-1:0] r_shift;
  logic [15:0]      r_scratch;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_d;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic [15:0]      w_corr;
  logic [31:0]      w_binExt;

  assign w_binExt = {{(32-BIN_W){1'b0}}, bif.i_bin};

  // Nibbles are corrected independently; a carry never crosses into the next digit.
  always_comb begin
    w_corr = r_scratch;
    for (int n = 0; n < 4; n++) begin
      if (r_scratch[4*n +: 4] >= 4'd5) begin
        w_corr[4*n +: 4] = r_scratch[4*n +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_d       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bif.i_start) begin
            r_shift   <= bif.i_bin;
            r_scratch <= '0;
            r_cnt     <= CNT_W'(BIN_W);
            r_ovf     <= (w_binExt > 32'd9999);
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= {w_corr[14:0], r_shift[BIN_W-1]};
          r_shift   <= {r_shift[BIN_W-2:0], 1'b0};
          r_cnt     <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // The raw thousands digit is garbage for inputs above 9999, so the whole word is replaced.
          r_d     <= r_ovf ? OVF_D : r_scratch;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bif.o_d    = r_d;
  assign bif.o_busy = r_busy;
  assign bif.o_done = r_done;
  assign bif.o_ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Directed, table-driven bench for bin_to_bcd4 at the default 14-bit width.
// Expected overflow result follows BCD_OVF_BLANK_EN the same way the build does.
module tb_bin_to_bcd4;

  localparam int BIN_W = 14;
  localparam int LAT   = BIN_W + 2;

`ifdef BCD_OVF_BLANK_EN
  localparam logic [15:0] EXP_OVF_D = 16'hFFFF;
`else
  localparam logic [15:0] EXP_OVF_D = 16'h9999;
`endif

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [15:0]      expD;
    logic             expOvf;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  int   totalCount = 0;
  int   badCount   = 0;
  vec_t vecs[12];

  always #5 clk = ~clk;

  bin_to_bcd4_if #(.BIN_W(BIN_W)) bif ();

  bin_to_bcd4 #(.BIN_W(BIN_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bif     (bif)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one Start pulse and follows the conversion to its Done cycle (or a timeout).
  task automatic applyStimulus(input logic [BIN_W-1:0] b, output logic [15:0] d,
                               output int doneAt, output int busyCnt, output logic ovf1);
    @(negedge clk);
    bif.i_start = 1'b1;
    bif.i_bin   = b;
    @(negedge clk);
    bif.i_start = 1'b0;
    bif.i_bin   = BIN_W'($urandom);
    ovf1    = bif.o_ovf;
    doneAt  = -1;
    busyCnt = 0;
    d       = 16'hxxxx;
    for (int k = 1; k <= 40; k++) begin
      if (bif.o_busy) busyCnt++;
      if (bif.o_done) begin
        doneAt = k;
        d      = bif.o_d;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] d1;
    logic [15:0] d2;
    int          doneAt;
    int          busyCnt;
    logic        ovf1;
    int          first;
    int          second;
    int          doneCnt;
    logic        ovfSeen;

    vecs[0]  = '{14'd0,     16'h0000, 1'b0};
    vecs[1]  = '{14'd1,     16'h0001, 1'b0};
    vecs[2]  = '{14'd9,     16'h0009, 1'b0};
    vecs[3]  = '{14'd10,    16'h0010, 1'b0};
    vecs[4]  = '{14'd99,    16'h0099, 1'b0};
    vecs[5]  = '{14'd1234,  16'h1234, 1'b0};
    vecs[6]  = '{14'd10000, EXP_OVF_D, 1'b1};
    vecs[7]  = '{14'd4095,  16'h4095, 1'b0};
    vecs[8]  = '{14'd8191,  16'h8191, 1'b0};
    vecs[9]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[10] = '{14'd16383, EXP_OVF_D, 1'b1};
    vecs[11] = '{14'd100,   16'h0100, 1'b0};

    rstN        = 1'b0;
    bif.i_start = 1'b0;
    bif.i_bin   = '0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_d",    32'(bif.o_d),    32'h0);
    checkOutput("reset_busy", 32'(bif.o_busy), 32'h0);
    checkOutput("reset_done", 32'(bif.o_done), 32'h0);
    checkOutput("reset_ovf",  32'(bif.o_ovf),  32'h0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].bin, d, doneAt, busyCnt, ovf1);
      checkOutput($sformatf("vec%0d_done_cycle", i), 32'(doneAt), 32'(BIN_W + 2));
      checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(busyCnt), 32'(BIN_W + 1));
      checkOutput($sformatf("vec%0d_d", i), 32'(d), 32'(vecs[i].expD));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf1), 32'(vecs[i].expOvf));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_width", i), 32'(bif.o_done), 32'h0);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("vec%0d_d_hold", i), 32'(bif.o_d), 32'(vecs[i].expD));
    end

    // Back-to-back: Start held high through the first Done cycle.
    @(negedge clk);
    bif.i_start = 1'b1;
    bif.i_bin   = 14'd0;
    @(negedge clk);
    bif.i_bin = 14'd9999;
    first   = -1;
    second  = -1;
    ovfSeen = 1'b0;
    d1      = 16'hxxxx;
    d2      = 16'hxxxx;
    for (int c = 1; c <= 60; c++) begin
      if (bif.o_ovf) ovfSeen = 1'b1;
      if (bif.o_done) begin
        if (first < 0) begin
          first = c;
          d1    = bif.o_d;
        end else begin
          second      = c;
          d2          = bif.o_d;
          bif.i_start = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    bif.i_start = 1'b0;
    checkOutput("b2b_first_done", 32'(first), 32'(BIN_W + 2));
    checkOutput("b2b_spacing", 32'(second - first), 32'(LAT));
    checkOutput("b2b_d_first", 32'(d1), 32'h0000);
    checkOutput("b2b_d_second", 32'(d2), 32'h9999);
    checkOutput("b2b_ovf_seen", 32'(ovfSeen), 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("b2b_idle_after", 32'(bif.o_busy), 32'h0);

    // Start during Busy is dropped, not queued.
    @(negedge clk);
    bif.i_start = 1'b1;
    bif.i_bin   = 14'd42;
    @(negedge clk);
    bif.i_start = 1'b0;
    repeat (4) @(negedge clk);
    bif.i_start = 1'b1;
    bif.i_bin   = 14'd77;
    @(negedge clk);
    bif.i_start = 1'b0;
    doneCnt = 0;
    d       = 16'hxxxx;
    for (int c = 0; c < 40; c++) begin
      if (bif.o_done) begin
        doneCnt++;
        d = bif.o_d;
      end
      @(negedge clk);
    end
    checkOutput("ignore_done_count", 32'(doneCnt), 32'h1);
    checkOutput("ignore_d", 32'(d), 32'h0042);

    // Reset at cycle 7 of a conversion aborts it.
    @(negedge clk);
    bif.i_start = 1'b1;
    bif.i_bin   = 14'd5678;
    @(negedge clk);
    bif.i_start = 1'b0;
    repeat (6) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("abort_busy", 32'(bif.o_busy), 32'h0);
    checkOutput("abort_d",    32'(bif.o_d),    32'h0000);
    checkOutput("abort_done", 32'(bif.o_done), 32'h0);
    doneCnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (bif.o_done) doneCnt++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(doneCnt), 32'h0);
    applyStimulus(14'd5678, d, doneAt, busyCnt, ovf1);
    checkOutput("rerun_done_cycle", 32'(doneAt), 32'(BIN_W + 2));
    checkOutput("rerun_d", 32'(d), 32'h5678);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
